hd_p2s_link_ctrl: RTL and testbench

//  Sequencer for one half-duplex parallel<->serial shift lane on a shared 1-bit bus.
//  - Accepts a command (TX, RX, or TX-then-RX) over a valid/ready interface.
//  - Drives the lane's load and parallel_en (bus-direction) controls; inserts bus turnaround.
//  - Captures the received word and returns it over a valid/ready response interface.
//  - Sits between the decoder's message-exchange control and each serial lane.

---
 rtl/hd_p2s_link_ctrl_pkg.sv | 24 ++
 rtl/hd_p2s_link_ctrl_phase_cnt.sv | 29 ++
 rtl/hd_p2s_link_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hd_p2s_link_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_p2s_link_ctrl_pkg.sv
// Shared definitions for the half-duplex lane sequencer: FSM state
// encoding, command mode codes and a small sizing helper.
package hd_p2s_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_TX_SHIFT = 3'd2,
        ST_TURN     = 3'd3,
        ST_RX_SHIFT = 3'd4,
        ST_CAPTURE  = 3'd5,
        ST_RESP     = 3'd6
    } state_t;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_TX   = 2'b01;
    localparam logic [1:0] CMD_RX   = 2'b10;
    localparam logic [1:0] CMD_TXRX = 2'b11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hd_p2s_link_ctrl_phase_cnt.sv
// Loadable down-counter that times the TX, turnaround and RX phases.
// It is loaded with (phase length - 1) on phase entry and the phase ends
// on the cycle the zero flag is high; it holds at zero rather than wrapping.
module hd_p2s_link_ctrl_phase_cnt #(
    parameter int WIDTH = 3
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hd_p2s_link_ctrl.sv
// Sequencer for one half-duplex parallel<->serial lane on a shared 1-bit
// bus. Takes TX / RX / TX-then-RX / no-op commands, drives the lane's load
// and bus-direction controls with a turnaround gap, and returns the
// received word on a valid/ready response port. All control outputs are
// registered from the next state so they line up with the state they
// belong to and never glitch.
module hd_p2s_link_ctrl
    import hd_p2s_link_ctrl_pkg::*;
#(
    parameter int MSG_WIDTH   = 4,
    parameter int TURN_CYCLES = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_mode,
    input  logic [MSG_WIDTH-1:0] cmd_data,
    output logic                 p2s_load,
    output logic                 p2s_parallel_en,
    output logic [MSG_WIDTH-1:0] p2s_parallel_in,
    input  logic [MSG_WIDTH-1:0] p2s_parallel_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MSG_WIDTH-1:0] rsp_data,
    output logic                 busy
);

    localparam int CNT_W = $clog2(max_int(MSG_WIDTH, TURN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MSG_LAST  = CNT_W'(MSG_WIDTH - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    state_t            state;
    state_t            next_state;
    logic [1:0]        mode_q;
    logic              accept;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_zero;
    logic              ready_nxt;
    logic              load_nxt;
    logic              en_nxt;
    logic              valid_nxt;
    logic              busy_nxt;

    assign accept = cmd_valid & cmd_ready;

    hd_p2s_link_ctrl_phase_cnt #(
        .WIDTH (CNT_W)
    ) u_phase_cnt (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // State register; reset drops straight back to IDLE mid-transfer
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Phase sequencing: each shift/turn phase ends when the counter hits zero
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_mode)
                        CMD_TX, CMD_TXRX: next_state = ST_LOAD;
                        CMD_RX:           next_state = ST_RX_SHIFT;
                        default:          next_state = ST_RESP;
                    endcase
                end
            end
            ST_LOAD: next_state = ST_TX_SHIFT;
            ST_TX_SHIFT: begin
                if (cnt_zero) begin
                    if (mode_q == CMD_TXRX) begin
                        next_state = (TURN_CYCLES > 0) ? ST_TURN : ST_RX_SHIFT;
                    end else begin
                        next_state = ST_RESP;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_zero) begin
                    next_state = ST_RX_SHIFT;
                end
            end
            ST_RX_SHIFT: begin
                if (cnt_zero) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Next-cycle control values and phase counter reload, decoded from next_state
    always_comb begin
        ready_nxt    = (next_state == ST_IDLE);
        load_nxt     = (next_state == ST_LOAD);
        en_nxt       = (next_state == ST_TX_SHIFT);
        valid_nxt    = (next_state == ST_RESP);
        busy_nxt     = (next_state != ST_IDLE);
        cnt_load     = 1'b0;
        cnt_load_val = MSG_LAST;
        if (next_state != state) begin
            case (next_state)
                ST_TX_SHIFT, ST_RX_SHIFT: cnt_load = 1'b1;
                ST_TURN: begin
                    cnt_load     = 1'b1;
                    cnt_load_val = TURN_LAST;
                end
                default: cnt_load = 1'b0;
            endcase
        end
    end

    // Registered control outputs so the bus direction never glitches
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cmd_ready       <= 1'b1;
            p2s_load        <= 1'b0;
            p2s_parallel_en <= 1'b0;
            rsp_valid       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            cmd_ready       <= ready_nxt;
            p2s_load        <= load_nxt;
            p2s_parallel_en <= en_nxt;
            rsp_valid       <= valid_nxt;
            busy            <= busy_nxt;
        end
    end

    // Command latch and response word: cleared on accept, filled in CAPTURE
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            mode_q          <= CMD_NOP;
            p2s_parallel_in <= '0;
            rsp_data        <= '0;
        end else begin
            if (accept) begin
                mode_q   <= cmd_mode;
                rsp_data <= '0;
                if (cmd_mode == CMD_TX || cmd_mode == CMD_TXRX) begin
                    p2s_parallel_in <= cmd_data;
                end
            end
            if (state == ST_CAPTURE) begin
                rsp_data <= p2s_parallel_out;
            end
        end
    end

endmodule

// File: tb/tb_hd_p2s_link_ctrl.sv
// Bench for hd_p2s_link_ctrl: models the shift lane and a peer that
// drives the shared bus during the receive window, with a scoreboard of
// expected response words and latencies.
module tb_hd_p2s_link_ctrl;
    import hd_p2s_link_ctrl_pkg::*;

    localparam int W = 4;

    logic         sys_clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_mode;
    logic [W-1:0] cmd_data;
    logic         p2s_load;
    logic         p2s_parallel_en;
    logic [W-1:0] p2s_parallel_in;
    logic [W-1:0] p2s_parallel_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         busy;

    logic [W-1:0] lane = '0;
    logic         peer_en;
    logic         peer_bit;
    logic         bus;
    logic         bus_driven;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        logic [W-1:0] data;
        int           lat;
    } exp_t;
    exp_t exp_q[$];

    hd_p2s_link_ctrl #(
        .MSG_WIDTH   (W),
        .TURN_CYCLES (1)
    ) dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_mode         (cmd_mode),
        .cmd_data         (cmd_data),
        .p2s_load         (p2s_load),
        .p2s_parallel_en  (p2s_parallel_en),
        .p2s_parallel_in  (p2s_parallel_in),
        .p2s_parallel_out (p2s_parallel_out),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .busy             (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Shared bus: lane drives when enabled, otherwise the peer may drive
    assign bus        = p2s_parallel_en ? lane[W-1] : peer_bit;
    assign bus_driven = p2s_parallel_en | peer_en;

    // Lane model: parallel load, else shift the bus into the LSB, MSB out
    always @(posedge sys_clk) begin
        if (p2s_load) lane <= p2s_parallel_in;
        else          lane <= {lane[W-2:0], bus};
    end
    assign p2s_parallel_out = lane;

    // Issue one command and follow it to its response, recording per-cycle traces
    task automatic run_cmd(input logic [1:0] mode, input logic [W-1:0] data,
                           input logic [W-1:0] peer_word, input int peer_start,
                           input bit auto_ack, output int lat, output logic [W-1:0] rdata,
                           output logic [31:0] en_tr, output logic [31:0] load_tr,
                           output logic [31:0] bus_tr, output logic [31:0] drv_tr,
                           output bit both_seen);
        en_tr = '0; load_tr = '0; bus_tr = '0; drv_tr = '0;
        lat = -1; rdata = 'x; both_seen = 0;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_data = data;
        for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge sys_clk);
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge sys_clk);
            if (peer_start > 0 && c >= peer_start && c < peer_start + W) begin
                peer_en  = 1'b1;
                peer_bit = peer_word[W-1-(c-peer_start)];
            end else begin
                peer_en = 1'b0;
            end
            #1;
            if (c < 32) begin
                en_tr[c]   = p2s_parallel_en;
                load_tr[c] = p2s_load;
                bus_tr[c]  = bus;
                drv_tr[c]  = bus_driven;
            end
            if (p2s_load && p2s_parallel_en) both_seen = 1;
            if (rsp_valid) begin
                lat   = c;
                rdata = rsp_data;
                break;
            end
        end
        peer_en = 1'b0;
        if (auto_ack) begin
            rsp_ready = 1'b1;
            @(posedge sys_clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_mode = CMD_NOP; cmd_data = '0;
        rsp_ready = 1'b0; peer_en = 1'b0; peer_bit = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else pass_cnt++;
        check_cnt++; if (p2s_load !== 1'b0) $display("FAIL reset_load: got %b want 0", p2s_load); else pass_cnt++;
        check_cnt++; if (p2s_parallel_en !== 1'b0) $display("FAIL reset_en: got %b want 0", p2s_parallel_en); else pass_cnt++;
        check_cnt++; if (p2s_parallel_in !== 4'h0) $display("FAIL reset_pin: got %h want 0", p2s_parallel_in); else pass_cnt++;
        check_cnt++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else pass_cnt++;
        check_cnt++; if (rsp_data !== 4'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        @(negedge sys_clk);
        rst = 1'b0;
    endtask

    task automatic test_tx();
        int lat; logic [W-1:0] rd; logic [31:0] en_tr, ld_tr, bus_tr, drv_tr; bit both; exp_t e;
        exp_q.push_back('{data: 4'b0000, lat: 6});
        run_cmd(CMD_TX, 4'b1011, 4'b0000, 0, 1, lat, rd, en_tr, ld_tr, bus_tr, drv_tr, both);
        e = exp_q.pop_front();
        check_cnt++; if (lat !== e.lat) $display("FAIL tx_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.data) $display("FAIL tx_rsp_data: got %b want %b", rd, e.data); else pass_cnt++;
        check_cnt++;
        if ({bus_tr[2], bus_tr[3], bus_tr[4], bus_tr[5]} !== 4'b1011)
            $display("FAIL tx_bus_bits: got %b want 1011", {bus_tr[2], bus_tr[3], bus_tr[4], bus_tr[5]});
        else pass_cnt++;
        check_cnt++; if (en_tr[6:1] !== 6'b011110) $display("FAIL tx_en_trace: got %b want 011110", en_tr[6:1]); else pass_cnt++;
        check_cnt++; if (ld_tr[6:1] !== 6'b000001) $display("FAIL tx_load_trace: got %b want 000001", ld_tr[6:1]); else pass_cnt++;
        check_cnt++; if (both !== 1'b0) $display("FAIL tx_load_en_overlap: got %b want 0", both); else pass_cnt++;
    endtask

    task automatic test_rx();
        int lat; logic [W-1:0] rd; logic [31:0] en_tr, ld_tr, bus_tr, drv_tr; bit both; exp_t e;
        exp_q.push_back('{data: 4'b0110, lat: 6});
        run_cmd(CMD_RX, 4'b1111, 4'b0110, 1, 1, lat, rd, en_tr, ld_tr, bus_tr, drv_tr, both);
        e = exp_q.pop_front();
        check_cnt++; if (lat !== e.lat) $display("FAIL rx_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.data) $display("FAIL rx_rsp_data: got %b want %b", rd, e.data); else pass_cnt++;
        check_cnt++; if (en_tr[6:1] !== 6'b0) $display("FAIL rx_en_trace: got %b want 000000", en_tr[6:1]); else pass_cnt++;
        check_cnt++; if (ld_tr[6:1] !== 6'b0) $display("FAIL rx_load_trace: got %b want 000000", ld_tr[6:1]); else pass_cnt++;
    endtask

    task automatic test_txrx();
        int lat; logic [W-1:0] rd; logic [31:0] en_tr, ld_tr, bus_tr, drv_tr; bit both; exp_t e;
        exp_q.push_back('{data: 4'b1001, lat: 12});
        run_cmd(CMD_TXRX, 4'b1100, 4'b1001, 7, 1, lat, rd, en_tr, ld_tr, bus_tr, drv_tr, both);
        e = exp_q.pop_front();
        check_cnt++; if (lat !== e.lat) $display("FAIL txrx_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.data) $display("FAIL txrx_rsp_data: got %b want %b", rd, e.data); else pass_cnt++;
        check_cnt++;
        if ({bus_tr[2], bus_tr[3], bus_tr[4], bus_tr[5]} !== 4'b1100)
            $display("FAIL txrx_bus_bits: got %b want 1100", {bus_tr[2], bus_tr[3], bus_tr[4], bus_tr[5]});
        else pass_cnt++;
        check_cnt++; if (drv_tr[6] !== 1'b0) $display("FAIL txrx_turnaround: bus driven %b want 0", drv_tr[6]); else pass_cnt++;
        check_cnt++; if (en_tr[12:6] !== 7'b0) $display("FAIL txrx_rx_en: got %b want 0000000", en_tr[12:6]); else pass_cnt++;
        check_cnt++; if (ld_tr[1] !== 1'b1) $display("FAIL txrx_load: got %b want 1", ld_tr[1]); else pass_cnt++;
        check_cnt++; if (both !== 1'b0) $display("FAIL txrx_load_en_overlap: got %b want 0", both); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int lat; logic [W-1:0] rd; logic [31:0] en_tr, ld_tr, bus_tr, drv_tr; bit both; exp_t e;
        exp_q.push_back('{data: 4'b0011, lat: 6});
        run_cmd(CMD_RX, 4'b0000, 4'b0011, 1, 0, lat, rd, en_tr, ld_tr, bus_tr, drv_tr, both);
        e = exp_q.pop_front();
        check_cnt++; if (lat !== e.lat) $display("FAIL bp_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.data) $display("FAIL bp_rsp_data: got %b want %b", rd, e.data); else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk);
            check_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, rsp_valid); else pass_cnt++;
            check_cnt++; if (rsp_data !== e.data) $display("FAIL bp_hold_data[%0d]: got %b want %b", k, rsp_data, e.data); else pass_cnt++;
            check_cnt++; if (cmd_ready !== 1'b0) $display("FAIL bp_hold_ready[%0d]: got %b want 0", k, cmd_ready); else pass_cnt++;
        end
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_mode = CMD_NOP; cmd_data = 4'h0;
        @(posedge sys_clk);
        #1 rsp_ready = 1'b0;
        check_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", rsp_valid); else pass_cnt++;
        check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", cmd_ready); else pass_cnt++;
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        check_cnt++; if (rsp_valid !== 1'b1) $display("FAIL bp_next_cmd_valid: got %b want 1", rsp_valid); else pass_cnt++;
        check_cnt++; if (rsp_data !== 4'h0) $display("FAIL bp_next_cmd_data: got %b want 0000", rsp_data); else pass_cnt++;
        rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1 rsp_ready = 1'b0;
        check_cnt++; if (busy !== 1'b0) $display("FAIL bp_final_busy: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_tx();
        int lat; logic [W-1:0] rd; logic [31:0] en_tr, ld_tr, bus_tr, drv_tr; bit both; exp_t e;
        @(negedge sys_clk);
        cmd_valid = 1'b1; cmd_mode = CMD_TX; cmd_data = 4'b1011;
        @(posedge sys_clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_cnt++; if (p2s_parallel_en !== 1'b1) $display("FAIL rst_mid_pre_en: got %b want 1", p2s_parallel_en); else pass_cnt++;
        rst = 1'b1;
        #1;
        check_cnt++; if (p2s_parallel_en !== 1'b0) $display("FAIL rst_mid_en: got %b want 0", p2s_parallel_en); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (cmd_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); else pass_cnt++;
        @(negedge sys_clk);
        rst = 1'b0;
        exp_q.push_back('{data: 4'b1010, lat: 6});
        run_cmd(CMD_RX, 4'b0000, 4'b1010, 1, 1, lat, rd, en_tr, ld_tr, bus_tr, drv_tr, both);
        e = exp_q.pop_front();
        check_cnt++; if (lat !== e.lat) $display("FAIL rst_mid_rx_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.data) $display("FAIL rst_mid_rx_data: got %b want %b", rd, e.data); else pass_cnt++;
    endtask

    task automatic test_nop();
        int lat; logic [W-1:0] rd; logic [31:0] en_tr, ld_tr, bus_tr, drv_tr; bit both; exp_t e;
        exp_q.push_back('{data: 4'b0000, lat: 1});
        run_cmd(CMD_NOP, 4'b1111, 4'b0000, 0, 1, lat, rd, en_tr, ld_tr, bus_tr, drv_tr, both);
        e = exp_q.pop_front();
        check_cnt++; if (lat !== e.lat) $display("FAIL nop_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.data) $display("FAIL nop_rsp_data: got %b want %b", rd, e.data); else pass_cnt++;
        check_cnt++; if ({en_tr[1], ld_tr[1]} !== 2'b00) $display("FAIL nop_lane_activity: got %b want 00", {en_tr[1], ld_tr[1]}); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx();
        test_txrx();
        test_nop();
        test_backpressure();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, check_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
